// File: rtl/logic_bus_arb_pkg.sv
// Shared definitions for the logic register bus arbiter: bus width defaults,
// arbiter FSM encoding and an index-width helper.
// Imported by logic_bus_arb and logic_bus_arb_rr.
package logic_bus_arb_pkg;

   localparam int LB_ADR_W = 12;
   localparam int LB_DAT_W = 16;

   // S_LOCK is the locked-idle wait: grant held between burst handshakes.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_XFER = 3'd1,
      S_ACK  = 3'd2,
      S_REL  = 3'd3,
      S_LOCK = 3'd4
   } arb_state_t;

   // Width of a master index; never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/logic_bus_arb_rr.sv
// Round-robin picker: one-hot winner among req, searching upward from the
// index after last (wrapping). Purely combinational, no state.
// Ports: req (request vector), last (last-served index), win (one-hot winner, 0 if no req).
module logic_bus_arb_rr
   import logic_bus_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  win
);

   // Walk distances from farthest to nearest so the nearest requester after
   // 'last' is written last and therefore wins.
   always_comb begin
      win = '0;
      for (int k = N; k >= 1; k--) begin
         for (int i = 0; i < N; i++) begin
            if (req[i] && (((int'(last) + k) % N) == i)) begin
               win    = '0;
               win[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/logic_bus_arb.sv
// Round-robin arbiter sharing the logic register bus between N_MST masters and
// one register-file slave. Grant held for one 4-phase handshake, or a locked burst.
// Slave outputs registered (1-cycle latency from request); m_ack/m_rd_data combinational.
// Ports: clk, rst (sync, active high); m_* per-master request side (packed, master i
// at [i*W +: W]); s_* slave side; gnt one-hot grant; err_timeout abort pulse.
// Optional feature: define ARB_TIMEOUT_EN to abort a transfer stuck for
// P_TIMEOUT_CNT cycles in one handshake phase; otherwise err_timeout is tied 0.
module logic_bus_arb
   import logic_bus_arb_pkg::*;
#(
   parameter int N_MST         = 2,
   parameter int P_ADR_W       = LB_ADR_W,
   parameter int P_DAT_W       = LB_DAT_W,
   parameter int P_TIMEOUT_CNT = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_MST-1:0]           m_wr_req,
   input  logic [N_MST-1:0]           m_rd_req,
   input  logic [N_MST-1:0]           m_lock,
   input  logic [N_MST*P_ADR_W-1:0]   m_adr,
   input  logic [N_MST*P_DAT_W-1:0]   m_wr_data,
   output logic [N_MST-1:0]           m_ack,
   output logic [P_DAT_W-1:0]         m_rd_data,
   output logic                       s_wr_req,
   output logic                       s_rd_req,
   output logic [P_ADR_W-1:0]         s_adr,
   output logic [P_DAT_W-1:0]         s_wr_data,
   input  logic                       s_ack,
   input  logic [P_DAT_W-1:0]         s_rd_data,
   output logic [N_MST-1:0]           gnt,
   output logic                       err_timeout
);

   localparam int IW = idx_w(N_MST);

   arb_state_t            state, state_nxt;
   logic [N_MST-1:0]      req_v, win, gnt_nxt;
   logic [IW-1:0]         win_idx, gnt_idx, gnt_idx_nxt, last_idx, last_idx_nxt, ld_idx;
   logic                  ld;
   logic                  g_wr, g_rd, g_lock;
   logic                  s_wr_req_nxt, s_rd_req_nxt;
   logic [P_ADR_W-1:0]    s_adr_nxt;
   logic [P_DAT_W-1:0]    s_wr_data_nxt;
   logic                  abort, abort_nxt;
   logic                  tmo;
   logic [P_ADR_W-1:0]    adr_a [N_MST];
   logic [P_DAT_W-1:0]    dat_a [N_MST];

   assign m_ack     = {N_MST{s_ack}} & gnt;
   assign m_rd_data = s_rd_data;
   assign req_v     = m_wr_req | m_rd_req;

   always_comb begin
      for (int i = 0; i < N_MST; i++) begin
         adr_a[i] = m_adr[i*P_ADR_W +: P_ADR_W];
         dat_a[i] = m_wr_data[i*P_DAT_W +: P_DAT_W];
      end
   end

   logic_bus_arb_rr #(.N(N_MST), .IW(IW)) u_rr (
      .req  (req_v),
      .last (last_idx),
      .win  (win)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N_MST; i++) begin
         if (win[i]) win_idx = IW'(i);
      end
   end

   // Request/lock of the currently granted master.
   assign g_wr   = m_wr_req[gnt_idx];
   assign g_rd   = m_rd_req[gnt_idx] & ~m_wr_req[gnt_idx];
   assign g_lock = m_lock[gnt_idx];

`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(P_TIMEOUT_CNT + 1);
   logic [TW-1:0] tcnt;
   logic          err_q;

   // Fires on the last allowed cycle of an XFER/ACK phase.
   assign tmo = ((state == S_XFER) || (state == S_ACK)) &&
                (tcnt == TW'(P_TIMEOUT_CNT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= tmo;
         if (state_nxt != state)
            tcnt <= '0;
         else if ((state == S_XFER) || (state == S_ACK))
            tcnt <= tcnt + 1'b1;
      end
   end

   assign err_timeout = err_q;
`else
   assign tmo         = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_comb begin
      state_nxt     = state;
      gnt_nxt       = gnt;
      gnt_idx_nxt   = gnt_idx;
      last_idx_nxt  = last_idx;
      s_wr_req_nxt  = s_wr_req;
      s_rd_req_nxt  = s_rd_req;
      s_adr_nxt     = s_adr;
      s_wr_data_nxt = s_wr_data;
      abort_nxt     = abort;
      ld            = 1'b0;
      ld_idx        = gnt_idx;

      case (state)
         S_IDLE: begin
            if (|req_v) begin
               gnt_nxt     = win;
               gnt_idx_nxt = win_idx;
               ld          = 1'b1;
               ld_idx      = win_idx;
               state_nxt   = S_XFER;
            end
         end
         S_XFER: begin
            if (s_ack) state_nxt = S_ACK;
         end
         S_ACK: begin
            // Follow the master's request, but never re-assert while ack is high.
            s_wr_req_nxt = g_wr & ~s_ack;
            s_rd_req_nxt = g_rd & ~s_ack;
            if (!s_ack && !(g_wr || g_rd)) state_nxt = S_REL;
         end
         S_REL: begin
            last_idx_nxt = gnt_idx;
            if (abort) begin
               // Aborted transfer: wait for the slave to let go of ack.
               if (!s_ack) begin
                  abort_nxt = 1'b0;
                  state_nxt = S_IDLE;
               end
            end else if (g_lock) begin
               state_nxt = S_LOCK;
            end else begin
               gnt_nxt   = '0;
               state_nxt = S_IDLE;
            end
         end
         S_LOCK: begin
            // Other masters are ignored while the owner keeps lock.
            if (!g_lock) begin
               gnt_nxt   = '0;
               state_nxt = S_IDLE;
            end else if (g_wr || g_rd) begin
               ld        = 1'b1;
               state_nxt = S_XFER;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // Address/data re-sampled on every entry to S_XFER.
      if (ld) begin
         s_wr_req_nxt  = m_wr_req[ld_idx];
         s_rd_req_nxt  = m_rd_req[ld_idx] & ~m_wr_req[ld_idx];
         s_adr_nxt     = adr_a[ld_idx];
         s_wr_data_nxt = dat_a[ld_idx];
      end

      // Timeout overrides everything, including lock.
      if (tmo) begin
         s_wr_req_nxt = 1'b0;
         s_rd_req_nxt = 1'b0;
         gnt_nxt      = '0;
         abort_nxt    = 1'b1;
         state_nxt    = S_REL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         gnt       <= '0;
         gnt_idx   <= '0;
         last_idx  <= IW'(N_MST - 1);
         s_wr_req  <= 1'b0;
         s_rd_req  <= 1'b0;
         s_adr     <= '0;
         s_wr_data <= '0;
         abort     <= 1'b0;
      end else begin
         state     <= state_nxt;
         gnt       <= gnt_nxt;
         gnt_idx   <= gnt_idx_nxt;
         last_idx  <= last_idx_nxt;
         s_wr_req  <= s_wr_req_nxt;
         s_rd_req  <= s_rd_req_nxt;
         s_adr     <= s_adr_nxt;
         s_wr_data <= s_wr_data_nxt;
         abort     <= abort_nxt;
      end
   end

endmodule

// File: tb/tb_logic_bus_arb.sv
// Directed bench for logic_bus_arb: single write, round-robin reads, locked
// burst, reset mid-handshake and stuck-slave behaviour (timeout build or not).
// Inputs driven and outputs sampled around the falling clock edge.
module tb_logic_bus_arb;

   localparam int N  = 2;
   localparam int AW = 12;
   localparam int DW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      m_wr_req, m_rd_req, m_lock, m_ack, gnt;
   logic [N*AW-1:0]   m_adr;
   logic [N*DW-1:0]   m_wr_data;
   logic [DW-1:0]     m_rd_data, s_wr_data, s_rd_data;
   logic              s_wr_req, s_rd_req, s_ack, err_timeout;
   logic [AW-1:0]     s_adr;

   int                n_chk = 0;
   int                n_err = 0;
   bit                ack_en;
   int                srv_q[$];
   logic [AW-1:0]     adr_q[$];
   logic [DW-1:0]     rdd_q[$];

   logic_bus_arb #(.N_MST(N), .P_ADR_W(AW), .P_DAT_W(DW), .P_TIMEOUT_CNT(16)) dut (
      .clk(clk), .rst(rst),
      .m_wr_req(m_wr_req), .m_rd_req(m_rd_req), .m_lock(m_lock),
      .m_adr(m_adr), .m_wr_data(m_wr_data), .m_ack(m_ack), .m_rd_data(m_rd_data),
      .s_wr_req(s_wr_req), .s_rd_req(s_rd_req), .s_adr(s_adr), .s_wr_data(s_wr_data),
      .s_ack(s_ack), .s_rd_data(s_rd_data), .gnt(gnt), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One cycle: slave acks while it sees a request; masters drop req on ack.
   task automatic tick();
      @(negedge clk);
      s_ack = ack_en & (s_wr_req | s_rd_req);
      #1;
      for (int i = 0; i < N; i++) begin
         if (m_ack[i] && (m_wr_req[i] || m_rd_req[i])) begin
            m_wr_req[i] = 1'b0;
            m_rd_req[i] = 1'b0;
            srv_q.push_back(i);
            adr_q.push_back(s_adr);
            rdd_q.push_back(m_rd_data);
         end
      end
   endtask

   task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m_adr[i*AW +: AW]     = a;
      m_wr_data[i*DW +: DW] = d;
      if (wr) m_wr_req[i] = 1'b1;
      else    m_rd_req[i] = 1'b1;
   endtask

   task automatic do_reset();
      m_wr_req = '0; m_rd_req = '0; m_lock = '0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (((m_wr_req | m_rd_req) != '0 || gnt != '0) && n < 80) begin
         tick();
         n++;
      end
      check(tag, {30'd0, gnt}, 32'd0);
   endtask

   int  n;
   int  who;
   bit  early, err_seen;

   initial begin
      m_adr = '0; m_wr_data = '0; s_ack = 1'b0; s_rd_data = 16'h5A5A;
      m_wr_req = '0; m_rd_req = '0; m_lock = '0;
      ack_en = 1'b1;
      do_reset();

      // Reset state
      check("rst_gnt",   {30'd0, gnt}, 32'd0);
      check("rst_wrreq", {31'd0, s_wr_req}, 32'd0);
      check("rst_rdreq", {31'd0, s_rd_req}, 32'd0);
      check("rst_adr",   {20'd0, s_adr}, 32'd0);
      check("rst_wdat",  {16'd0, s_wr_data}, 32'd0);
      check("rst_err",   {31'd0, err_timeout}, 32'd0);

      // 1: single write from master 0
      set_req(0, 1'b1, 12'h123, 16'hBEEF);
      tick();
      check("t1_wrreq", {31'd0, s_wr_req}, 32'd1);
      check("t1_rdreq", {31'd0, s_rd_req}, 32'd0);
      check("t1_adr",   {20'd0, s_adr}, 32'h123);
      check("t1_wdat",  {16'd0, s_wr_data}, 32'hBEEF);
      check("t1_gnt",   {30'd0, gnt}, 32'd1);
      check("t1_mack",  {30'd0, m_ack}, 32'd1);
      n = 0;
      do begin tick(); n++; end while (gnt != '0 && n < 50);
      check("t1_release_cycles", n, 4);
      check("t1_wrreq_low", {31'd0, s_wr_req}, 32'd0);

      // 2: both masters read, four rounds
      do_reset();
      srv_q.delete(); rdd_q.delete(); adr_q.delete();
      for (int r = 0; r < 4; r++) begin
         set_req(0, 1'b0, 12'h040, 16'h0);
         set_req(1, 1'b0, 12'h041, 16'h0);
         drain("t2_round_idle");
      end
      check("t2_count", srv_q.size(), 8);
      for (int k = 0; k < 8; k++) begin
         who = (srv_q.size() > k) ? srv_q[k] : 99;
         check("t2_order", who, k % 2);
         check("t2_rdata", (rdd_q.size() > k) ? {16'd0, rdd_q[k]} : 32'hDEAD, 32'h5A5A);
      end

      // 3: locked burst from master 1 while master 0 keeps requesting
      srv_q.delete(); adr_q.delete(); rdd_q.delete();
      m_lock[1] = 1'b1;
      set_req(1, 1'b1, 12'h010, 16'h1000);
      tick();
      check("t3_gnt_m1", {30'd0, gnt}, 32'd2);
      set_req(0, 1'b0, 12'h0AA, 16'h0);
      early = 1'b0;
      for (int w = 0; w < 3; w++) begin
         if (w > 0) set_req(1, 1'b1, 12'h010 + 12'(w), 16'h1000 + 16'(w));
         n = 0;
         while (srv_q.size() <= w && n < 30) begin
            tick(); n++;
            if (gnt == 2'b01) early = 1'b1;
         end
         who = (srv_q.size() > w) ? srv_q[w] : 99;
         check("t3_word_master", who, 1);
         check("t3_word_adr", (adr_q.size() > w) ? {20'd0, adr_q[w]} : 32'hDEAD, 32'h010 + w);
         for (int j = 0; j < ((w == 2) ? 4 : 3); j++) begin
            tick();
            if (gnt == 2'b01) early = 1'b1;
         end
      end
      check("t3_no_m0_while_locked", {31'd0, early}, 32'd0);
      m_lock[1] = 1'b0;
      n = 0;
      do begin tick(); n++; end while (gnt != 2'b01 && n < 20);
      check("t3_m0_after_unlock", n, 2);
      drain("t3_idle");

      // 4: reset while in S_ACK
      set_req(1, 1'b1, 12'h200, 16'h2222);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("t4_gnt", {30'd0, gnt}, 32'd0);
      check("t4_wrreq", {31'd0, s_wr_req}, 32'd0);
      check("t4_rdreq", {31'd0, s_rd_req}, 32'd0);
      rst = 1'b0;
      set_req(0, 1'b0, 12'h201, 16'h0);
      set_req(1, 1'b0, 12'h202, 16'h0);
      tick();
      check("t4_first_after_rst", {30'd0, gnt}, 32'd1);
      drain("t4_idle");

`ifdef ARB_TIMEOUT_EN
      // 5: stuck slave, timeout after 16 cycles in S_XFER
      do_reset();
      ack_en = 1'b0;
      set_req(0, 1'b1, 12'h300, 16'h3333);
      n = 0;
      do begin tick(); n++; end while (!err_timeout && n < 40);
      check("t5_err_cycle", n, 17);
      check("t5_gnt_cleared", {30'd0, gnt}, 32'd0);
      check("t5_wrreq_cleared", {31'd0, s_wr_req}, 32'd0);
      m_wr_req[0] = 1'b0;
      tick();
      check("t5_err_pulse", {31'd0, err_timeout}, 32'd0);
      tick(); tick();
      ack_en = 1'b1;
      set_req(1, 1'b0, 12'h301, 16'h0);
      tick();
      check("t5_regrant", {30'd0, gnt}, 32'd2);
      drain("t5_idle");
`else
      // 6: stuck slave, no timeout: grant held indefinitely
      do_reset();
      ack_en = 1'b0;
      set_req(0, 1'b1, 12'h300, 16'h3333);
      err_seen = 1'b0;
      repeat (10000) begin
         tick();
         if (err_timeout) err_seen = 1'b1;
      end
      check("t6_no_err", {31'd0, err_seen}, 32'd0);
      check("t6_gnt_held", {30'd0, gnt}, 32'd1);
      check("t6_wrreq_held", {31'd0, s_wr_req}, 32'd1);
      ack_en = 1'b1;
      do_reset();
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
